// File: rtl/booth_div8.sv
// Sequential signed/unsigned integer divider: restoring radix-2 on operand magnitudes,
// followed by one sign-correction cycle. Fixed latency of WIDTH+1 edges after start.
module booth_div8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [1:0]       sign_mode,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH:0]   b_mag_r;
    logic [WIDTH-1:0] dividend_r;
    logic [3:0]       cnt_r;
    logic             neg_a_r;
    logic             neg_q_r;
    logic             dbz_r;
    logic             ovf_r;

    logic [WIDTH:0]   a_mag_s;
    logic [WIDTH:0]   b_mag_s;
    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;
    logic [WIDTH-1:0] fix_q_s;
    logic [WIDTH-1:0] fix_r_s;

    // Signed operands with MSB set are negated into a WIDTH+1 field so the most
    // negative value keeps its full magnitude.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] op, input logic is_signed);
        logic [WIDTH:0] ext;
        ext = {is_signed & op[WIDTH-1], op};
        if (is_signed && op[WIDTH-1]) begin
            magnitude = ~ext + (WIDTH+1)'(1);
        end else begin
            magnitude = ext;
        end
    endfunction

    // Operand magnitudes, trial subtraction and sign-corrected results.
    always_comb begin
        a_mag_s   = magnitude(dividend, sign_mode[1]);
        b_mag_s   = magnitude(divisor, sign_mode[0]);
        shifted_s = {rem_r, q_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, b_mag_r};
        if (dbz_r) begin
            fix_q_s = {WIDTH{1'b1}};
            fix_r_s = dividend_r;
        end else begin
            fix_q_s = neg_q_r ? (~q_r + WIDTH'(1)) : q_r;
            fix_r_s = neg_a_r ? (~rem_r[WIDTH-1:0] + WIDTH'(1)) : rem_r[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            q_r         <= {WIDTH{1'b0}};
            rem_r       <= {(WIDTH+1){1'b0}};
            b_mag_r     <= {(WIDTH+1){1'b0}};
            dividend_r  <= {WIDTH{1'b0}};
            cnt_r       <= 4'd0;
            neg_a_r     <= 1'b0;
            neg_q_r     <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        q_r        <= a_mag_s[WIDTH-1:0];
                        b_mag_r    <= b_mag_s;
                        dividend_r <= dividend;
                        rem_r      <= {(WIDTH+1){1'b0}};
                        cnt_r      <= 4'd0;
                        neg_a_r    <= sign_mode[1] & dividend[WIDTH-1];
                        neg_q_r    <= (sign_mode[1] & dividend[WIDTH-1]) ^ (sign_mode[0] & divisor[WIDTH-1]);
                        dbz_r      <= (divisor == {WIDTH{1'b0}});
                        ovf_r      <= (sign_mode == 2'b11) &&
                                      (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                      (divisor == {WIDTH{1'b1}});
                        busy       <= 1'b1;
                        state_r    <= ITER;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ITER: begin
                    // A clear top bit means the trial subtraction did not go negative.
                    if (trial_s[WIDTH+1] == 1'b0) begin
                        rem_r <= trial_s[WIDTH:0];
                        q_r   <= {q_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= shifted_s[WIDTH:0];
                        q_r   <= {q_r[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_r == 4'(WIDTH-1)) begin
                        state_r <= FIX;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                FIX: begin
                    quotient    <= fix_q_s;
                    remainder   <= fix_r_s;
                    div_by_zero <= dbz_r;
                    overflow    <= ovf_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_div8.sv
// Scoreboard bench for booth_div8: the driver queues expected results at each accepted
// start, an independent monitor pops and compares on every done pulse.
module tb_booth_div8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'h00;
    logic [7:0] divisor = 8'h00;
    logic [1:0] sign_mode = 2'b00;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       overflow;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   n_issued = 0;

    booth_div8 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .sign_mode(sign_mode), .quotient(quotient), .remainder(remainder), .busy(busy),
        .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard.
    initial begin
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                check("done_width", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got q=%0h r=%0h want no done", quotient, remainder);
                end else begin
                    e = sb.pop_front();
                    check("quotient", {24'd0, quotient}, {24'd0, e.q});
                    check("remainder", {24'd0, remainder}, {24'd0, e.r});
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                    check("latency", cyc, e.due);
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                end
            end
            prev_done = done;
        end
    end

    // Call at a negedge; drives start for the next edge and records the expectation.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sm,
                         input logic [7:0] q, input logic [7:0] r, input logic dbz, input logic ovf);
        dividend  = a;
        divisor   = b;
        sign_mode = sm;
        start     = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{q: q, r: r, dbz: dbz, ovf: ovf, due: cyc + 9});
        n_issued++;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start     = 1'b0;
        dividend  = $urandom_range(255, 0);
        divisor   = $urandom_range(255, 0);
        sign_mode = 2'($urandom_range(3, 0));
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_quotient", {24'd0, quotient}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors: dividend, divisor, sign_mode -> quotient, remainder, flags.
        issue(8'd100, 8'd7, 2'b00, 8'h0E, 8'h02, 1'b0, 1'b0);
        wait_empty();
        repeat (3) @(negedge clk);
        check("hold_quotient", {24'd0, quotient}, 32'h0E);
        check("hold_remainder", {24'd0, remainder}, 32'h02);
        issue(8'h9C, 8'h07, 2'b11, 8'hF2, 8'hFE, 1'b0, 1'b0); wait_empty(); @(negedge clk);
        issue(8'h64, 8'hF9, 2'b11, 8'hF2, 8'h02, 1'b0, 1'b0); wait_empty(); @(negedge clk);
        issue(8'hF9, 8'hFA, 2'b10, 8'h00, 8'hF9, 1'b0, 1'b0); wait_empty(); @(negedge clk);
        issue(8'hFF, 8'h10, 2'b00, 8'h0F, 8'h0F, 1'b0, 1'b0); wait_empty(); @(negedge clk);
        issue(8'h55, 8'h00, 2'b11, 8'hFF, 8'h55, 1'b1, 1'b0); wait_empty(); @(negedge clk);
        issue(8'h80, 8'hFF, 2'b11, 8'h80, 8'h00, 1'b0, 1'b1); wait_empty(); @(negedge clk);
        issue(8'h80, 8'hFF, 2'b00, 8'h00, 8'h80, 1'b0, 1'b0); wait_empty(); @(negedge clk);

        // Handshake: starts at the 3rd and 9th edges after acceptance are ignored,
        // the one at the 10th edge is accepted.
        issue(8'd100, 8'd7, 2'b00, 8'h0E, 8'h02, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            start     = (i == 3 || i == 9);
            dividend  = 8'd50;
            divisor   = 8'd5;
            sign_mode = 2'b00;
            @(negedge clk);
        end
        issue(8'd50, 8'd5, 2'b00, 8'h0A, 8'h00, 1'b0, 1'b0);
        wait_empty();
        @(negedge clk);

        // Reset in the middle of a division: outputs clear at once, no done follows.
        dividend  = 8'd100;
        divisor   = 8'd7;
        sign_mode = 2'b00;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_quotient", {24'd0, quotient}, 32'd0);
        check("midrst_remainder", {24'd0, remainder}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_busy_after", {31'd0, busy}, 32'd0);

        issue(8'd9, 8'd3, 2'b00, 8'h03, 8'h00, 1'b0, 1'b0);
        wait_empty();
        repeat (2) @(negedge clk);
        check("done_count", done_cnt, n_issued);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
